mc_control_fsm: RTL

Multi-cycle main controller for the RV32I core. It sequences the shared datapath (single memory port, one ALU, ALU-out register, instruction register, immediate sign extender) over several cycles per instruction. It drives `imm_src` to the immediate extender and all mux selects and write enables. It sits between the instruction register fields and the datapath, and replaces the combinational decoder of the single-cycle build.

---
 rtl/mc_control_fsm.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller for the RV32I core: sequences fetch, decode and execute over the shared datapath.
// Optional macro RV_ILLEGAL_TRAP_EN: unknown opcodes trap to a terminal TRAP state and set the sticky illegal flag.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_LUI, S_ALUWB, S_BRANCH, S_JALR, S_JAL
`ifdef RV_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  state_e state_q, state_d;
  logic   taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src = 3'b000;
    case (opcode)
      OP_STORE:        imm_src = 3'b001;
      OP_BRANCH:       imm_src = 3'b010;
      OP_LUI, OP_AUIPC: imm_src = 3'b011;
      OP_JAL:          imm_src = 3'b100;
      default:         imm_src = 3'b000;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  // Next state and datapath controls; anything not set in a state stays 0.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready && rst_n) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
`ifdef RV_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = taken;
        state_d   = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
`ifdef RV_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

`ifdef RV_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule
